// File: rtl/keypad_emulator.sv
// Keypad-side model of a 4x4 matrix: queues key codes and answers the scanner's column drive on RowIn.
// Latency: a key pushed into an idle empty queue is popped one edge later; RowIn drops on the edge where ColOut matches.
// Backpressure: key_ready falls when the queue holds FIFO_DEPTH codes; pushes while full are ignored.
module keypad_emulator #(
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int RELEASE_CYCLES = 4,
  parameter int SCAN_TIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          key_valid,
  input  logic [3:0]                    key_code,
  output logic                          key_ready,
  input  logic                          flush,
  input  logic [3:0]                    ColOut,
  output logic [3:0]                    RowIn,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   queued,
  output logic                          key_done,
  output logic                          timeout_err
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int QW   = AW + 1;
  localparam int TW   = $clog2(SCAN_TIMEOUT);
  localparam int CMAX = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_COL = 2'd1;
  localparam logic [1:0] PRESS    = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cur_q, cur_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    rowin_q, rowin_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic [QW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic          push, pop;

  assign key_ready   = (count_q < QW'(FIFO_DEPTH));
  assign queued      = count_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);
  assign RowIn       = rowin_q;
  assign key_done    = done_q;
  assign timeout_err = tmo_q;

  // Next-state: key FSM, queue bookkeeping, and flush override (flush beats everything).
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    rowin_d = rowin_q;
    tmo_d   = 1'b0;
    pop     = 1'b0;
    push    = key_valid && key_ready && !flush;

    case (state_q)
      IDLE: begin
        rowin_d = 4'hF;
        if (count_q != '0) begin
          pop     = 1'b1;
          cur_d   = mem_q[rd_ptr_q];
          timer_d = '0;
          state_d = WAIT_COL;
        end
      end
      WAIT_COL: begin
        // A non-one-hot ColOut can never equal a single-zero pattern, so it never matches.
        if (ColOut == ~(4'b0001 << cur_q[1:0])) begin
          state_d = PRESS;
          rowin_d = ~(4'b0001 << cur_q[3:2]);
          cnt_d   = '0;
        end else if (timer_q == TW'(SCAN_TIMEOUT - 1)) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PRESS: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = RELEASE;
          rowin_d = 4'hF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        rowin_d = 4'hF;
        if (cnt_q == CW'(RELEASE_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    if (flush) begin
      state_d = IDLE;
      rowin_d = 4'hF;
      timer_d = '0;
      cnt_d   = '0;
      tmo_d   = 1'b0;
      pop     = 1'b0;
    end

    // key_done is registered, so raise it on the edge that enters the last release cycle.
    done_d = (state_d == RELEASE) && (cnt_d == CW'(RELEASE_CYCLES - 1));

    wr_ptr_d = flush ? '0 : (push ? wr_ptr_q + AW'(1) : wr_ptr_q);
    rd_ptr_d = flush ? '0 : (pop  ? rd_ptr_q + AW'(1) : rd_ptr_q);
    count_d  = flush ? '0 : (count_q + QW'(push) - QW'(pop));
  end

  // State, counters and queue pointers with asynchronous reset.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      timer_q  <= '0;
      cnt_q    <= '0;
      rowin_q  <= 4'hF;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      rowin_q  <= rowin_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Queue storage; contents are only read when count_q says they are valid, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= key_code;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator (FIFO_DEPTH=4, HOLD=8, RELEASE=4, TIMEOUT=64).
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// ColOut either held constant or rotated 1110->1101->1011->0111, four cycles per step.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_ready;
  logic       flush = 1'b0;
  logic [3:0] ColOut = 4'hF;
  logic [3:0] RowIn;
  logic       busy;
  logic [2:0] queued;
  logic       key_done;
  logic       timeout_err;

  int tests = 0;
  int failed = 0;
  int done_cnt = 0;
  int tmo_cnt = 0;
  bit rot_en = 1'b0;
  int rot_cnt = 0;
  logic [3:0] col_at_edge = 4'hF;

  keypad_emulator #(
    .FIFO_DEPTH(4), .HOLD_CYCLES(8), .RELEASE_CYCLES(4), .SCAN_TIMEOUT(64)
  ) dut (
    .clk(clk), .RST(RST), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .flush(flush), .ColOut(ColOut), .RowIn(RowIn),
    .busy(busy), .queued(queued), .key_done(key_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rot_pat(input int c);
    case ((c / 4) % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic tick();
    col_at_edge = ColOut;
    @(posedge clk);
    #1;
    if (rot_en) begin
      rot_cnt++;
      ColOut = rot_pat(rot_cnt);
    end
  endtask

  task automatic start_rot();
    rot_en  = 1'b1;
    rot_cnt = 0;
    ColOut  = 4'b1110;
  endtask

  // Follow one key: row pattern and the column it matched, 8 held cycles, key_done in the 4th released cycle.
  task automatic run_key(input logic [3:0] exp_row, input logic [3:0] exp_col, input string tag);
    int n;
    n = 0;
    while (RowIn === 4'hF && n < 300) begin tick(); n++; end
    chk(RowIn, exp_row, {tag, "_row"});
    chk(col_at_edge, exp_col, {tag, "_col"});
    n = 0;
    while (RowIn === exp_row && n < 40) begin tick(); n++; end
    chk(n, 8, {tag, "_hold"});
    chk(RowIn, 4'hF, {tag, "_rel"});
    n = 1;
    while (key_done !== 1'b1 && n < 20) begin tick(); n++; end
    chk(n, 4, {tag, "_done_at"});
    chk(RowIn, 4'hF, {tag, "_rel_end"});
    tick();
    chk(key_done, 1'b0, {tag, "_done_pulse"});
  endtask

  // Pulse counters and row-line legality, sampled mid-cycle.
  always @(negedge clk) begin
    if (!RST) begin
      if (key_done === 1'b1) done_cnt++;
      if (timeout_err === 1'b1) tmo_cnt++;
      chk((RowIn === 4'hF || RowIn === 4'hE || RowIn === 4'hD || RowIn === 4'hB || RowIn === 4'h7),
          1'b1, "row_legal");
    end
  end

  initial begin
    int n, d0, t0;
    bit saw_low;

    // 1. Reset applied before any clock edge must set outputs immediately.
    #2 RST = 1'b1;
    #1;
    chk(RowIn, 4'hF, "rst_rowin_async");
    chk(queued, 3'd0, "rst_queued");
    chk(key_ready, 1'b1, "rst_ready");
    chk(busy, 1'b0, "rst_busy");
    chk(key_done, 1'b0, "rst_done");
    chk(timeout_err, 1'b0, "rst_tmo");
    tick(); tick();
    RST = 1'b0;
    tick();
    chk(key_ready, 1'b1, "post_rst_ready");
    chk(queued, 3'd0, "post_rst_queued");
    chk(busy, 1'b0, "post_rst_busy");

    // 2. Single key code 2 (row0, col2) under rotation.
    start_rot();
    key_valid = 1'b1; key_code = 4'd2;
    tick();
    key_valid = 1'b0;
    chk(queued, 3'd1, "t2_queued");
    chk(busy, 1'b1, "t2_busy");
    run_key(4'b1110, 4'b1011, "t2_k2");
    chk(busy, 1'b0, "t2_busy_fall");
    chk(done_cnt, 1, "t2_done_cnt");

    // 3. Queue order and full behaviour with ColOut idle.
    rot_en = 1'b0; ColOut = 4'hF;
    d0 = done_cnt;
    key_valid = 1'b1; key_code = 4'd2;  tick();
    key_code = 4'd11; tick();
    chk(queued, 3'd1, "t3_q_after_pop");
    key_code = 4'd4;  tick();
    key_code = 4'd12; tick();
    chk(queued, 3'd3, "t3_q3");
    chk(key_ready, 1'b1, "t3_ready_q3");
    key_code = 4'd1;  tick();
    chk(queued, 3'd4, "t3_q4");
    chk(key_ready, 1'b0, "t3_ready_full");
    key_code = 4'd6;  tick();
    key_code = 4'd9;  tick();
    key_valid = 1'b0;
    chk(queued, 3'd4, "t3_full_ignored");
    start_rot();
    run_key(4'b1110, 4'b1011, "t3_k2");
    run_key(4'b1011, 4'b0111, "t3_k11");
    run_key(4'b1101, 4'b1110, "t3_k4");
    run_key(4'b0111, 4'b1110, "t3_k12");
    run_key(4'b1110, 4'b1101, "t3_k1");
    chk(done_cnt - d0, 5, "t3_done_cnt");
    chk(busy, 1'b0, "t3_idle");

    // 4. Timeout: code 3 needs ColOut 0111, held at 1110 instead.
    rot_en = 1'b0; ColOut = 4'b1110;
    d0 = done_cnt; t0 = tmo_cnt;
    key_valid = 1'b1; key_code = 4'd3;
    tick();
    key_valid = 1'b0;
    n = 0; saw_low = 1'b0;
    while (timeout_err !== 1'b1 && n < 200) begin
      tick(); n++;
      if (RowIn !== 4'hF) saw_low = 1'b1;
    end
    chk(n, 65, "t4_tmo_at");
    chk(saw_low, 1'b0, "t4_row_high");
    tick();
    chk(timeout_err, 1'b0, "t4_tmo_pulse");
    chk(tmo_cnt - t0, 1, "t4_tmo_cnt");
    chk(done_cnt - d0, 0, "t4_no_done");
    key_valid = 1'b1; key_code = 4'd0;
    tick();
    key_valid = 1'b0;
    run_key(4'b1110, 4'b1110, "t4_k0");

    // 5. Flush in the middle of a press with two keys queued; simultaneous push is dropped.
    d0 = done_cnt; t0 = tmo_cnt;
    key_valid = 1'b1; key_code = 4'd0;  tick();
    key_code = 4'd5;  tick();
    key_code = 4'd10; tick();
    key_valid = 1'b0;
    chk(RowIn, 4'b1110, "t5_pressing");
    chk(queued, 3'd2, "t5_queued2");
    tick(); tick();
    flush = 1'b1; key_valid = 1'b1; key_code = 4'd7;
    tick();
    flush = 1'b0; key_valid = 1'b0;
    chk(RowIn, 4'hF, "t5_flush_row");
    chk(queued, 3'd0, "t5_flush_queued");
    chk(busy, 1'b0, "t5_flush_busy");
    chk(key_ready, 1'b1, "t5_flush_ready");
    for (int i = 0; i < 20; i++) tick();
    chk(done_cnt - d0, 0, "t5_no_done");
    chk(tmo_cnt - t0, 0, "t5_no_tmo");
    chk(busy, 1'b0, "t5_stays_idle");

    // 6. Push in the same cycle as the pop keeps occupancy at 1; both keys emitted in order.
    ColOut = 4'hF;
    key_valid = 1'b1; key_code = 4'd5;
    tick();
    chk(queued, 3'd1, "t6_q1");
    key_code = 4'd14;
    tick();
    key_valid = 1'b0;
    chk(queued, 3'd1, "t6_pushpop_q");
    start_rot();
    run_key(4'b1101, 4'b1101, "t6_k5");
    run_key(4'b0111, 4'b1011, "t6_k14");
    chk(busy, 1'b0, "t6_idle");

    // 7. Asynchronous reset during a press releases the row without a clock edge.
    rot_en = 1'b0; ColOut = 4'b1110;
    key_valid = 1'b1; key_code = 4'd0;
    tick();
    key_valid = 1'b0;
    n = 0;
    while (RowIn !== 4'b1110 && n < 10) begin tick(); n++; end
    chk(RowIn, 4'b1110, "t7_pressing");
    #2 RST = 1'b1;
    #1;
    chk(RowIn, 4'hF, "t7_async_row");
    chk(busy, 1'b0, "t7_async_busy");
    tick();
    RST = 1'b0;
    tick();
    chk(RowIn, 4'hF, "t7_post_row");
    chk(queued, 3'd0, "t7_post_queued");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
